// File: rtl/dct_mac_pipe.sv
// Pipelined signed multiply-accumulate for the forward-DCT datapath: sums TAPS
// sample*coefficient products per result, then rounds, shifts and saturates.
module dct_mac_pipe #(
    parameter int DATA_W      = 12,
    parameter int COEF_W      = 12,
    parameter int TAPS        = 8,
    parameter int ROUND_SHIFT = 0,
    parameter int OUT_W       = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ena_i,
    input  logic                     dclr_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [OUT_W-1:0]  dout_o,
    output logic                     sat_o
);
    localparam int MULT_W  = DATA_W + COEF_W;
    localparam int ACC_W   = MULT_W + $clog2(TAPS) + 1;
    localparam int SUM_W   = ACC_W + 1;
    localparam int EXT_W   = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    localparam int TAP_W   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int RND_POS = (ROUND_SHIFT > 0) ? ROUND_SHIFT - 1 : 0;

    localparam logic [TAP_W-1:0]        TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic signed [SUM_W-1:0] RND      = (ROUND_SHIFT > 0) ? (SUM_W'(1) << RND_POS) : '0;
    localparam logic signed [EXT_W-1:0] SAT_MAX  = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN  = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [TAP_W-1:0]         tap_q;
    logic signed [DATA_W-1:0] din_q;
    logic signed [COEF_W-1:0] coef_q;
    logic [TAP_W-1:0]         p1_tap_q;
    logic                     p1_v_q;
    logic signed [MULT_W-1:0] mult_q;
    logic [TAP_W-1:0]         p2_tap_q;
    logic                     p2_v_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  dout_q;
    logic                     sat_q;

    logic                     stall;
    logic                     accept;
    logic                     res_load;
    logic [TAP_W-1:0]         tap_d;
    logic signed [MULT_W-1:0] din_ext;
    logic signed [MULT_W-1:0] coef_ext;
    logic signed [MULT_W-1:0] mult_d;
    logic signed [ACC_W-1:0]  mult_acc;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [SUM_W-1:0]  sum_rnd;
    logic signed [SUM_W-1:0]  sum_sh;
    logic signed [EXT_W-1:0]  res_ext;
    logic signed [OUT_W-1:0]  dout_d;
    logic                     sat_d;

    always_comb begin
        stall      = !ena_i || (out_valid_q && !out_ready_i);
        in_ready_o = !rst_i && !stall;
        accept     = in_valid_i && in_ready_o;
        tap_d      = (tap_q == TAP_LAST) ? '0 : tap_q + 1'b1;

        din_ext  = {{COEF_W{din_q[DATA_W-1]}}, din_q};
        coef_ext = {{DATA_W{coef_q[COEF_W-1]}}, coef_q};
        mult_d   = din_ext * coef_ext;

        // Tap 0 starts a fresh block, so the old sum is dropped rather than cleared separately.
        mult_acc = {{(ACC_W-MULT_W){mult_q[MULT_W-1]}}, mult_q};
        acc_base = (p2_tap_q == '0) ? '0 : acc_q;
        acc_d    = acc_base + mult_acc;
        res_load = p2_v_q && (p2_tap_q == TAP_LAST);

        sum_rnd = {acc_d[ACC_W-1], acc_d} + RND;
        sum_sh  = sum_rnd >>> ROUND_SHIFT;
        res_ext = {{(EXT_W-SUM_W){sum_sh[SUM_W-1]}}, sum_sh};

        dout_d = res_ext[OUT_W-1:0];
        sat_d  = 1'b0;
        if (res_ext > SAT_MAX) begin
            dout_d = {1'b0, {(OUT_W-1){1'b1}}};
            sat_d  = 1'b1;
        end else if (res_ext < SAT_MIN) begin
            dout_d = {1'b1, {(OUT_W-1){1'b0}}};
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tap_q       <= '0;
            din_q       <= '0;
            coef_q      <= '0;
            p1_tap_q    <= '0;
            p1_v_q      <= 1'b0;
            mult_q      <= '0;
            p2_tap_q    <= '0;
            p2_v_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
        end else if (ena_i && dclr_i) begin
            // Abort drops the partial block but a finished result still waits to be taken.
            tap_q  <= '0;
            p1_v_q <= 1'b0;
            p2_v_q <= 1'b0;
            acc_q  <= '0;
            if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end else if (!stall) begin
            if (accept) begin
                din_q    <= din_i;
                coef_q   <= coef_i;
                p1_tap_q <= tap_q;
                tap_q    <= tap_d;
            end
            p1_v_q   <= accept;
            mult_q   <= mult_d;
            p2_tap_q <= p1_tap_q;
            p2_v_q   <= p1_v_q;
            if (p2_v_q) begin
                acc_q <= acc_d;
            end
            // Not stalled implies any held result is being consumed this cycle.
            if (res_load) begin
                out_valid_q <= 1'b1;
                dout_q      <= dout_d;
                sat_q       <= sat_d;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign dout_o      = dout_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Scoreboard bench for dct_mac_pipe: one instance with 8 taps and no shift,
// one with a single tap and a rounding shift of 2.
module tb_dct_mac_pipe;
    localparam int DW     = 12;
    localparam int CW     = 12;
    localparam int OW     = 16;
    localparam int TAPS_A = 8;
    localparam int RS_A   = 0;
    localparam int TAPS_B = 1;
    localparam int RS_B   = 2;

    typedef struct {
        int d;
        int s;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_a = 1'b1, ena_a = 1'b1, dclr_a = 1'b0, iv_a = 1'b0, or_a = 1'b1;
    logic                 ir_a, ov_a, sat_a;
    logic signed [DW-1:0] din_a = '0;
    logic signed [CW-1:0] coef_a = '0;
    logic signed [OW-1:0] dout_a;

    logic                 rst_b = 1'b1, iv_b = 1'b0, or_b = 1'b1;
    logic                 ir_b, ov_b, sat_b;
    logic signed [DW-1:0] din_b = '0;
    logic signed [CW-1:0] coef_b = '0;
    logic signed [OW-1:0] dout_b;

    dct_mac_pipe #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS_A), .ROUND_SHIFT(RS_A), .OUT_W(OW)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .ena_i(ena_a), .dclr_i(dclr_a),
        .in_valid_i(iv_a), .in_ready_o(ir_a), .din_i(din_a), .coef_i(coef_a),
        .out_valid_o(ov_a), .out_ready_i(or_a), .dout_o(dout_a), .sat_o(sat_a)
    );

    dct_mac_pipe #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS_B), .ROUND_SHIFT(RS_B), .OUT_W(OW)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .ena_i(1'b1), .dclr_i(1'b0),
        .in_valid_i(iv_b), .in_ready_o(ir_b), .din_i(din_b), .coef_i(coef_b),
        .out_valid_o(ov_b), .out_ready_i(or_b), .dout_o(dout_b), .sat_o(sat_b)
    );

    int     n_pass = 0;
    int     n_total = 0;
    res_t   q_a[$];
    res_t   q_b[$];
    longint psum_a = 0;
    int     pcnt_a = 0;
    int     bp_left = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: exact sum, add half an LSB, floor-divide by 2^rs, clamp to OUT_W.
    function automatic res_t ref_result(input longint sum, input int rs);
        res_t   r;
        longint v, div, hi, lo;
        div = 1;
        for (int i = 0; i < rs; i++) div = div * 2;
        v = sum;
        if (rs > 0) v = v + div / 2;
        if (v >= 0) v = v / div;
        else v = -((-v + div - 1) / div);
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -hi - 1;
        r.s = 0;
        if (v > hi) begin v = hi; r.s = 1; end
        else if (v < lo) begin v = lo; r.s = 1; end
        r.d = int'(v);
        return r;
    endfunction

    function automatic int rnd_s12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // Monitors: compare whenever a result is handed over; also require a held result to stay put.
    res_t mon_e_a, mon_e_b;
    bit   pend_a = 1'b0, pend_b = 1'b0;
    int   last_d_a, last_s_a, last_d_b, last_s_b;

    always @(negedge clk) begin
        if (pend_a && ov_a) begin
            check("A_hold_dout", dout_a, last_d_a);
            check("A_hold_sat", sat_a, last_s_a);
        end
        if (!rst_a && ov_a && or_a && ena_a) begin
            if (q_a.size() == 0) begin
                n_total++;
                $display("FAIL A_unexpected_out: got dout %0d, expected no result", dout_a);
            end else begin
                mon_e_a = q_a.pop_front();
                check("A_dout", dout_a, mon_e_a.d);
                check("A_sat", sat_a, mon_e_a.s);
            end
        end
        pend_a   = !rst_a && ov_a && !(or_a && ena_a);
        last_d_a = dout_a;
        last_s_a = sat_a;
    end

    always @(negedge clk) begin
        if (pend_b && ov_b) check("B_hold_dout", dout_b, last_d_b);
        if (!rst_b && ov_b && or_b) begin
            if (q_b.size() == 0) begin
                n_total++;
                $display("FAIL B_unexpected_out: got dout %0d, expected no result", dout_b);
            end else begin
                mon_e_b = q_b.pop_front();
                check("B_dout", dout_b, mon_e_b.d);
                check("B_sat", sat_b, mon_e_b.s);
            end
        end
        pend_b   = !rst_b && ov_b && !or_b;
        last_d_b = dout_b;
        last_s_b = sat_b;
    end

    task automatic cyc_a(input bit v, input int d, input int c, input bit en, input bit ordy,
                         input bit clr, input bit rs, output bit acc);
        bit bp_now;
        @(posedge clk);
        #1;
        bp_now = 1'b0;
        if (bp_left > 0 && ov_a) begin
            ordy   = 1'b0;
            bp_now = 1'b1;
            bp_left--;
        end
        rst_a  = rs;
        ena_a  = en;
        dclr_a = clr;
        iv_a   = v;
        din_a  = DW'(d);
        coef_a = CW'(c);
        or_a   = ordy;
        @(negedge clk);
        if (bp_now) check("A_bp_in_ready", ir_a, 0);
        if (!en) check("A_ena_in_ready", ir_a, 0);
        acc = v && ir_a;
        if (rs || (clr && en)) begin
            psum_a = 0;
            pcnt_a = 0;
        end else if (acc) begin
            psum_a = psum_a + longint'(d) * longint'(c);
            pcnt_a++;
            if (pcnt_a == TAPS_A) begin
                q_a.push_back(ref_result(psum_a, RS_A));
                psum_a = 0;
                pcnt_a = 0;
            end
        end
    endtask

    task automatic send_a(input int d, input int c, input int en_off_pct, input int rdy_off_pct);
        bit acc, en, clr;
        for (int t = 0; t < 200; t++) begin
            en  = ($urandom_range(0, 99) >= en_off_pct);
            clr = !en && ($urandom_range(0, 1) == 1);
            cyc_a(1'b1, d, c, en, ($urandom_range(0, 99) >= rdy_off_pct), clr, 1'b0, acc);
            if (acc) return;
        end
        n_total++;
        $display("FAIL A_send_timeout: sample %0d*%0d not accepted within 200 cycles", d, c);
    endtask

    task automatic idle_a(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) cyc_a(1'b0, 0, 0, 1'b1, ordy, 1'b0, 1'b0, acc);
    endtask

    task automatic ramp_a(input int c, input int rdy_off_pct);
        for (int i = 1; i <= 8; i++) send_a(i, c, 0, rdy_off_pct);
    endtask

    task automatic cyc_b(input bit v, input int d, input int c, input bit ordy, input bit rs, output bit acc);
        @(posedge clk);
        #1;
        rst_b  = rs;
        iv_b   = v;
        din_b  = DW'(d);
        coef_b = CW'(c);
        or_b   = ordy;
        @(negedge clk);
        acc = v && ir_b;
        if (acc && !rs) q_b.push_back(ref_result(longint'(d) * longint'(c), RS_B));
    endtask

    task automatic send_b(input int d, input int c, input int rdy_off_pct);
        bit acc;
        for (int t = 0; t < 100; t++) begin
            cyc_b(1'b1, d, c, ($urandom_range(0, 99) >= rdy_off_pct), 1'b0, acc);
            if (acc) return;
        end
        n_total++;
        $display("FAIL B_send_timeout: sample %0d*%0d not accepted within 100 cycles", d, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int exp_ov[4];
        int w;
        exp_ov = '{0, 0, 1, 0};

        // Reset state
        cyc_a(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
        cyc_a(1'b1, 5, 5, 1'b1, 1'b1, 1'b0, 1'b1, acc);
        check("A_rst_in_ready", ir_a, 0);
        check("A_rst_out_valid", ov_a, 0);
        check("A_rst_dout", dout_a, 0);
        check("A_rst_sat", sat_a, 0);

        // Contiguous 1..8 * 2, ready in the first cycle after reset, fixed latency
        cyc_a(1'b1, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0, acc);
        check("A_first_ready", acc, 1);
        for (int i = 2; i <= 8; i++) send_a(i, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle_a(1, 1'b1);
            check("A_latency_out_valid", ov_a, exp_ov[i]);
        end
        idle_a(4, 1'b1);

        // Saturation both ways
        for (int i = 0; i < 8; i++) send_a(-2048, -2048, 0, 0);
        for (int i = 0; i < 8; i++) send_a(-2048, 2047, 0, 0);
        idle_a(6, 1'b1);

        // Backpressure: hold out_ready low 5 cycles while the source keeps pushing
        bp_left = 5;
        ramp_a(2, 0);
        ramp_a(2, 0);
        idle_a(8, 1'b1);

        // Three back-to-back random blocks with ena dropped ~30% of cycles
        for (int i = 0; i < 3 * TAPS_A; i++) send_a(rnd_s12(), rnd_s12(), 30, 0);
        idle_a(8, 1'b1);

        // Abort via dclr after 4th accept; the sample in that cycle is dropped
        for (int i = 0; i < 4; i++) send_a(rnd_s12(), rnd_s12(), 0, 0);
        cyc_a(1'b1, rnd_s12(), rnd_s12(), 1'b1, 1'b1, 1'b1, 1'b0, acc);
        check("A_dclr_in_ready", acc, 1);
        ramp_a(2, 0);
        idle_a(6, 1'b1);

        // Abort via reset after 4th accept
        for (int i = 0; i < 4; i++) send_a(rnd_s12(), rnd_s12(), 0, 0);
        cyc_a(1'b1, rnd_s12(), rnd_s12(), 1'b1, 1'b1, 1'b0, 1'b1, acc);
        check("A_midrst_in_ready", acc, 0);
        ramp_a(2, 0);
        idle_a(6, 1'b1);

        // A result pending at dclr survives and is delivered unchanged
        ramp_a(3, 100);
        w = 0;
        while (!ov_a && w < 10) begin
            idle_a(1, 1'b0);
            w++;
        end
        check("A_pending_seen", ov_a, 1);
        cyc_a(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        check("A_pending_kept", ov_a, 1);
        idle_a(3, 1'b1);
        ramp_a(2, 0);
        idle_a(6, 1'b1);

        // Mixed random traffic with ena and out_ready both toggling
        for (int i = 0; i < 5 * TAPS_A; i++) send_a(rnd_s12(), rnd_s12(), 15, 30);
        idle_a(8, 1'b1);

        // Single-tap instance: reset state, rounding corners, then random
        cyc_b(1'b1, 1, 1, 1'b1, 1'b1, acc);
        check("B_rst_in_ready", ir_b, 0);
        check("B_rst_out_valid", ov_b, 0);
        send_b(3, 2, 0);
        send_b(-3, 2, 0);
        send_b(-2, 3, 0);
        send_b(1, 2, 0);
        send_b(-1, 2, 0);
        send_b(-2048, -2048, 0);
        for (int i = 0; i < 40; i++) send_b(rnd_s12(), rnd_s12(), 30);
        for (int i = 0; i < 6; i++) cyc_b(1'b0, 0, 0, 1'b1, 1'b0, acc);

        w = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && w < 50) begin
            idle_a(1, 1'b1);
            w++;
        end
        check("A_queue_drained", q_a.size(), 0);
        check("B_queue_drained", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dct_mac_pipe.md
# dct_mac_pipe

Parametrised, pipelined multiply-accumulate unit for the forward-DCT datapath of `jpeg_encoder`. It replaces the fixed-width per-coefficient `macu` inside each `dct_unit`. Per cycle it takes one signed sample and coefficient pair, registers the product in `mult_res`, and accumulates `TAPS` products into one result. The result is rounded, shifted and saturated. Compared with the fixed `macu`, it adds valid/ready flow control, a global clock enable, a block abort, and a saturation flag.

## Interface

Parameters:

- `DATA_W`, 12: signed sample width.
- `COEF_W`, 12: signed coefficient width.
- `TAPS`, 8: products per result, ≥1.
- `ROUND_SHIFT`, 0: right shift applied to the final sum (0 = none).
- `OUT_W`, 16: signed output width.
- Derived, not overridable:
  - MULT_W = DATA_W+COEF_W
  - ACC_W = MULT_W+clog2(TAPS)+1

Ports:

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `ena`, in, 1: global clock enable; 0 freezes all state.
- `dclr`, in, 1: synchronous abort of the partial block.
- `in_valid`, in, 1: `din`/`coef` valid.
- `in_ready`, out, 1: sample accepted when `in_valid && in_ready`.
- `din`, in, DATA_W: signed sample.
- `coef`, in, COEF_W: signed coefficient.
- `out_valid`, out, 1: `dout` valid.
- `out_ready`, in, 1: consumer accepts `dout`.
- `dout`, out, OUT_W: signed result.
- `sat`, out, 1: `dout` was saturated; qualified by `out_valid`.

## Operation

- Stall:
  - stall = !ena || (out_valid && !out_ready).
  - in_ready = !rst && !stall (combinational).
  - While stalled, every pipeline register, valid bit and counter holds.
- Pipeline stage P1 (on accept):
  - Captures `din`, `coef` and the tap index into din_r, coef_r and p1_tap.
  - Sets p1_v.
  - The tap counter increments, wrapping from TAPS-1 to 0.
  - Without accept (and no stall), p1_v clears.
- Pipeline stage P2:
  - mult_res = signed(din_r) × signed(coef_r), full MULT_W bits.
  - p2_v and p2_tap follow P1.
- Pipeline stage P3, when p2_v:
  - acc_next = (p2_tap==0 ? 0 : acc) + sign-extended mult_res.
  - acc ← acc_next.
- Output, when p2_v and p2_tap==TAPS-1:
  - r = (acc_next + (ROUND_SHIFT ? 1<<(ROUND_SHIFT-1) : 0)) >>> ROUND_SHIFT. This is round-half-up with an arithmetic shift.
  - If r exceeds the OUT_W signed range, `dout` takes the max or min value and `sat`=1. Otherwise `dout`=r[OUT_W-1:0] and `sat`=0.
  - `out_valid` is set.
- Output handshake:
  - `out_valid` clears on `out_ready && ena`, unless a new result loads in the same cycle.
  - A new result can only load when not stalled, so an unconsumed result is never overwritten.
- ACC_W guarantees no accumulator overflow for any input values. Saturation occurs only at the output.
- `TAPS`=1: every accepted sample produces one result.
- `dclr` (when `ena`):
  - Clears the tap counter, p1_v, p2_v and acc.
  - A pending `out_valid`/`dout` is preserved.
  - A sample presented in the same cycle is dropped: in_ready is still asserted, but the sample is discarded.
- Priority: rst > dclr > stall > normal operation.
- `rst` (regardless of `ena`):
  - All valids, counters, acc, `dout` and `sat` go to 0.
  - `in_ready`=0 during the reset cycle.
  - Mid-block reset discards partial sums.

## Timing

- Reset values:
  - `out_valid`=0, `dout`=0, `sat`=0.
  - `in_ready`=0 while `rst`=1, then 1 in the first cycle after reset (if `ena`).
- Latency: the last tap of a block accepted in cycle n gives `out_valid`=1 in cycle n+3, with no stalls.
- Throughput:
  - One sample per cycle sustained.
  - One result every TAPS cycles.
  - Back-to-back blocks have no bubbles.
- Stall behaviour: each stall cycle adds exactly one cycle of latency. Results are bit-identical to the unstalled run.
- `out_valid` is held with `dout` stable until it is consumed.

## Test plan

- DATA_W=COEF_W=12, TAPS=8, ROUND_SHIFT=0:
  - Stimulus: din=1..8, coef=2, contiguous.
  - Expected: `dout`=72 and `sat`=0, `out_valid` exactly 3 cycles after the 8th accept, for one cycle.
- Saturation, OUT_W=16:
  - Stimulus: eight samples din=-2048, coef=-2048 (sum 33554432).
  - Expected: `dout`=32767, `sat`=1.
  - Repeat with coef=+2047: `dout`=-32768, `sat`=1.
- Rounding, ROUND_SHIFT=2, TAPS=1:
  - din=3, coef=2 → `dout`=2.
  - din=-3, coef=2 → `dout`=-1.
  - din=-2, coef=3 → `dout`=-1.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles after `out_valid` while the source keeps `in_valid`=1.
  - Expected: `dout` stable, `in_ready`=0, and no sample lost or duplicated. The next block also gives 72.
- `ena` toggling:
  - Stimulus: random `ena` deassertion (about 30%) during three back-to-back blocks.
  - Expected: the `dout` sequence is identical to the `ena`=1 run.
- Abort:
  - Stimulus: `dclr` after the 4th accept of a block, or `rst` in the same position.
  - Expected: the next 8 samples (din=1..8, coef=2) yield `dout`=72.
  - A result pending at `dclr` is still delivered unchanged.
